// File: rtl/mem_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_rr_if
//  Purpose  : Bundle of the N requesting masters and the shared CPU-side bus
//             seen by mem_arbiter_rr.
//  Ports    : slave modport  - arbiter side (takes requests, drives grant/bus)
//             master modport - requester/memory side (drives requests, bus_rdy)
//  Signals  : req/lock/m_rw [N], m_addr [N*AW], m_wdata [N*DW], bus_rdy,
//             grant/m_rdy [N], grant_id [$clog2(N)], grant_valid,
//             bus_addr [AW], bus_wdata [DW], bus_rw
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_rr_if #(
   parameter int N  = 4,
   parameter int AW = 16,
   parameter int DW = 8
);
   logic [N-1:0]         req;
   logic [N-1:0]         lock;
   logic [N*AW-1:0]      m_addr;
   logic [N*DW-1:0]      m_wdata;
   logic [N-1:0]         m_rw;
   logic [N-1:0]         grant;
   logic [$clog2(N)-1:0] grant_id;
   logic                 grant_valid;
   logic [N-1:0]         m_rdy;
   logic [AW-1:0]        bus_addr;
   logic [DW-1:0]        bus_wdata;
   logic                 bus_rw;
   logic                 bus_rdy;

   modport slave (
      input  req, lock, m_addr, m_wdata, m_rw, bus_rdy,
      output grant, grant_id, grant_valid, m_rdy, bus_addr, bus_wdata, bus_rw
   );

   modport master (
      output req, lock, m_addr, m_wdata, m_rw, bus_rdy,
      input  grant, grant_id, grant_valid, m_rdy, bus_addr, bus_wdata, bus_rw
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_rr
//  Purpose  : N-master memory-bus arbiter with registered one-hot grant,
//             round-robin (FIXED=0) or fixed-priority (FIXED=1) selection,
//             per-owner burst limit (MAX_BURST, 0 = unlimited) with lock
//             override, and a combinational mux of the owner onto the bus.
//  Ports    : clk       - clock, all state changes on the rising edge
//             sys_reset - synchronous active-high reset
//             arb       - mem_arbiter_rr_if.slave (requests, grant, bus)
//  Options  : ARB_PARK_EN - when defined, a release with no other requester
//             parks the grant on the last owner instead of going idle.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
   parameter int N         = 4,
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int FIXED     = 0,
   parameter int MAX_BURST = 8
) (
   input  logic            clk,
   input  logic            sys_reset,
   mem_arbiter_rr_if.slave arb
);

   localparam int IW = $clog2(N);
   // Counter must hold the value MAX_BURST itself (saturation point).
   localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

   localparam logic [CW-1:0] c_burst_max  = CW'(MAX_BURST);
   localparam logic [CW-1:0] c_burst_last = CW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
   localparam logic [IW-1:0] c_last_id    = IW'(N - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t        r_state,     w_state_nxt;
   logic [N-1:0]  r_grant,     w_grant_nxt;
   logic [IW-1:0] r_grant_id,  w_grant_id_nxt;
   logic [IW-1:0] r_rr_ptr,    w_rr_ptr_nxt;
   logic [CW-1:0] r_burst_cnt, w_burst_cnt_nxt;

   logic [N-1:0]  w_others;
   logic [IW-1:0] w_after_owner;
   logic [IW-1:0] w_start;
   logic          w_owner_req;
   logic          w_preempt;
   logic          w_valid;

   // First set bit of mask searching upward from start, modulo N.
   function automatic logic [IW-1:0] f_pick(input logic [N-1:0] mask,
                                            input logic [IW-1:0] start);
      logic found;
      int   j;
      f_pick = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(start) + k) % N;
         if (!found && mask[j]) begin
            found  = 1'b1;
            f_pick = IW'(j);
         end
      end
   endfunction

   function automatic logic [N-1:0] f_onehot(input logic [IW-1:0] id);
      f_onehot     = '0;
      f_onehot[id] = 1'b1;
   endfunction

   assign w_others      = arb.req & ~r_grant;
   assign w_owner_req   = arb.req[r_grant_id];
   assign w_after_owner = (r_grant_id == c_last_id) ? '0 : r_grant_id + 1'b1;
   // Fixed priority always scans from 0; the owner is already masked out of
   // w_others, so a handover can never re-select it.
   assign w_start       = (FIXED != 0) ? '0 : w_after_owner;
   // >= rather than == so a burst held past the limit by lock hands over on
   // the first cycle lock drops while the counter sits saturated.
   assign w_preempt     = (MAX_BURST != 0) && (r_burst_cnt >= c_burst_last) &&
                          !arb.lock[r_grant_id] && (|w_others);

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_id_nxt  = r_grant_id;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_burst_cnt_nxt = r_burst_cnt;
      case (r_state)
         ST_IDLE: begin
            if (|arb.req) begin
               w_state_nxt     = ST_OWN;
               w_grant_id_nxt  = f_pick(arb.req, (FIXED != 0) ? '0 : r_rr_ptr);
               w_burst_cnt_nxt = '0;
            end
         end
         ST_OWN: begin
            // A stalled bus freezes everything, including a pending release.
            if (arb.bus_rdy) begin
               if (!w_owner_req) begin
                  w_rr_ptr_nxt    = w_after_owner;
                  w_burst_cnt_nxt = '0;
                  if (|w_others) begin
                     w_grant_id_nxt = f_pick(w_others, w_start);
                  end else begin
`ifdef ARB_PARK_EN
                     w_state_nxt = ST_OWN;
`else
                     w_state_nxt = ST_IDLE;
`endif
                  end
               end else if (w_preempt) begin
                  w_rr_ptr_nxt    = w_after_owner;
                  w_burst_cnt_nxt = '0;
                  w_grant_id_nxt  = f_pick(w_others, w_start);
               end else if (r_burst_cnt != c_burst_max) begin
                  w_burst_cnt_nxt = r_burst_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_grant_nxt = (w_state_nxt == ST_OWN) ? f_onehot(w_grant_id_nxt) : '0;
   end

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_grant_id  <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_id  <= w_grant_id_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   assign w_valid         = (r_state == ST_OWN);
   assign arb.grant       = r_grant;
   assign arb.grant_id    = r_grant_id;
   assign arb.grant_valid = w_valid;
   assign arb.m_rdy       = r_grant & arb.req & {N{arb.bus_rdy}};
   assign arb.bus_addr    = w_valid ? arb.m_addr[r_grant_id*AW +: AW]  : '0;
   assign arb.bus_wdata   = w_valid ? arb.m_wdata[r_grant_id*DW +: DW] : '0;
   assign arb.bus_rw      = w_valid ? arb.m_rw[r_grant_id]             : 1'b1;

endmodule
`default_nettype wire

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-master memory-bus arbiter; successor to the fixed 2-way CPU/APU arbitration in the system top.
- Registered one-hot grant, round-robin or fixed-priority mode.
- Per-owner burst limit with lock override.
- Muxes the granted master's address/data/rw onto the shared CPU-side bus, honours bus_rdy stalls, returns per-master ready.

Parameters:
- N, 4, number of masters (2..8).
- AW, 16, address width.
- DW, 8, data width.
- FIXED, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
- MAX_BURST, 8, max consecutive completed transfers by one owner while another master waits; 0 = unlimited.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- sys_reset, input, 1, synchronous active-high reset.
- req, input, N, per-master request; held until served or withdrawn.
- lock, input, N, owner keeps bus past MAX_BURST (RMW, DMA page).
- m_addr, input, N*AW, packed addresses; master i at [i*AW +: AW].
- m_wdata, input, N*DW, packed write data.
- m_rw, input, N, 1 = read, 0 = write.
- grant, output, N, registered one-hot grant.
- grant_id, output, $clog2(N), index of current owner.
- grant_valid, output, 1, any grant asserted.
- m_rdy, output, N, comb: grant[i] & req[i] & bus_rdy; transfer completes this cycle.
- bus_addr, output, AW, granted master's address; 0 when no grant.
- bus_wdata, output, DW, granted master's data; 0 when no grant.
- bus_rw, output, 1, granted master's rw; 1 (read) when no grant.
- bus_rdy, input, 1, shared-bus ready; low stalls the transfer.

Behaviour:
- Reset (synchronous, on any edge with sys_reset=1):
  - grant=0, grant_valid=0, grant_id=0, burst_cnt=0, rr_ptr=0.
  - Bus outputs idle: addr 0, wdata 0, rw 1.
  - Reset mid-burst discards ownership; no m_rdy in the following cycle.
- States:
  - IDLE (grant_valid=0).
  - OWN (grant_valid=1).
- IDLE -> OWN: any req=1 at edge. Winner registered; grant visible next cycle (1-cycle request-to-grant latency).
- Winner selection:
  - RR: first requester searching upward from rr_ptr, modulo N.
  - FIXED: lowest-index requester.
- OWN, bus_rdy=0: grant, burst_cnt, rr_ptr frozen. No handover during a stall, even if req[owner] drops.
- OWN, bus_rdy=1, req[owner]=0 (release):
  - Re-arbitrate among current req at the same edge, so there is no idle gap.
  - rr_ptr=owner+1 mod N; burst_cnt=0.
  - No other requester -> IDLE.
- OWN, bus_rdy=1, req[owner]=1:
  - burst_cnt increments, saturating at MAX_BURST.
  - Handover (preempt) at this edge iff all of: MAX_BURST!=0, burst_cnt==MAX_BURST-1, lock[owner]=0, another master requesting.
  - Next owner chosen with rr_ptr=owner+1 (RR) or fixed priority excluding the current owner (FIXED); burst_cnt=0.
  - If lock[owner]=1 or no other requester: retain ownership. burst_cnt sits at MAX_BURST; handover happens on the first cycle lock drops and another master requests.
- Bus outputs:
  - Combinational mux of the granted master by grant_id.
  - m_rdy only to the owner; non-owners see m_rdy=0 and must hold their req.
- Simultaneous events:
  - All N request from IDLE after reset: RR grants 0; FIXED grants 0.
  - Owner drops req while a stall ends: release takes effect on the first bus_rdy=1 edge.
- Width rule: grant_id width $clog2(N); rr_ptr wraps N-1 -> 0.

Optional Feature:
- Macro: ARB_PARK_EN.
- Defined:
  - On release with no other requester, grant stays parked on the last owner: grant_valid=1, bus outputs still driven by that master.
  - A new req from the parked master gets m_rdy in the same cycle (0-cycle latency).
  - A req from any other master moves the grant at the next edge.
  - burst_cnt=0 while parked.
- Undefined: release with no other requester returns to IDLE as above.

Test Plan:
1. N=4, RR, bus_rdy=1. After reset, req=4'b1111 held. grant sequence 0001 -> 0010 (after 8 transfers) -> 0100 -> 1000 -> 0001. Exactly 8 m_rdy pulses per owner.
2. Master 2 alone: req[2]=1 at cycle 5. grant=0100 at cycle 6. m_rdy[2]=1 from cycle 6. bus_addr=m_addr[2] (e.g. 16'h0700).
3. Owner 1 with lock[1]=1, req[3]=1, 20 transfers. No handover. Drop lock at transfer 20 -> grant=1000 next edge.
4. bus_rdy=0 for 5 cycles mid-burst at burst_cnt=6, master 0 waiting. grant and burst_cnt frozen. Handover after 2 more completed transfers.
5. FIXED=1, req=4'b1010 from IDLE. Grant 1. After 8 transfers preempt to 3. Release of 3 with req[1] still set -> grant returns to 1.
6. sys_reset pulse while grant=0100 and burst_cnt=4. Next cycle grant=0, bus_rw=1, bus_addr=0. With req=1111 the next grant is 0001.
